// File: rtl/time_of_day_counter_if.sv
// Control inputs and time outputs of the time-of-day counter.
interface time_of_day_counter_if;
  logic       run;
  logic [1:0] sel;
  logic       inc_btn;
  logic       dec_btn;
  logic [5:0] s;
  logic [5:0] m;
  logic [4:0] h;
  logic [4:0] h_disp;
  logic       pm;
  logic       tick_1hz;
  logic       day_wrap;
  logic       edit_active;

  // Master drives controls (button front-end side), slave is the counter.
  modport master (
    output run, sel, inc_btn, dec_btn,
    input  s, m, h, h_disp, pm, tick_1hz, day_wrap, edit_active
  );

  modport slave (
    input  run, sel, inc_btn, dec_btn,
    output s, m, h, h_disp, pm, tick_1hz, day_wrap, edit_active
  );
endinterface

// File: rtl/time_of_day_counter.sv
// 24-hour time-of-day counter with internal 1 Hz prescaler, field edit mode
// with press-and-hold auto-repeat, 12-hour display conversion and day-wrap pulse.
module time_of_day_counter #(
  parameter int unsigned CLK_DIV   = 100000000,
  parameter int unsigned REP_DELAY = 50000000,
  parameter int unsigned REP_RATE  = 10000000
) (
  input logic                  clk,
  input logic                  reset,
  time_of_day_counter_if.slave bus
);

  localparam int unsigned PW   = $clog2(CLK_DIV);
  localparam int unsigned RMAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int unsigned RW   = $clog2(RMAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  rep_state_t    state;
  logic [PW-1:0] presc;
  logic [RW-1:0] rep_cnt;
  logic          rep_up;
  logic [1:0]    rep_sel;
  logic          inc_q;
  logic          dec_q;
  logic [5:0]    s_r;
  logic [5:0]    m_r;
  logic [4:0]    h_r;
  logic          tick_r;
  logic          wrap_r;

  logic counting;
  logic presc_wrap;
  logic inc_press;
  logic dec_press;
  logic arm;
  logic abort;
  logic step;
  logic step_up;

  // Wrapping +/-1 within 0..top, no carry out.
  function automatic logic [5:0] step_field(input logic [5:0] v, input logic [5:0] top,
                                            input logic up);
    if (up) return (v == top) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? top : v - 6'd1;
  endfunction

  // Press detection, repeat abort conditions and step request.
  always_comb begin
    counting   = bus.run && (bus.sel == 2'b00);
    presc_wrap = counting && (presc == PW'(CLK_DIV - 1));
    inc_press  = bus.inc_btn && !inc_q;
    dec_press  = bus.dec_btn && !dec_q;
    arm        = (bus.sel != 2'b00) && (inc_press || dec_press) &&
                 !(bus.inc_btn && bus.dec_btn);
    abort      = (rep_up ? !bus.inc_btn : !bus.dec_btn) ||
                 (rep_up ? bus.dec_btn : bus.inc_btn) ||
                 (bus.sel != rep_sel) || (bus.sel == 2'b00);
    step       = 1'b0;
    step_up    = 1'b0;
    case (state)
      IDLE: begin
        step    = arm;
        step_up = inc_press;
      end
      DELAY, REPEAT: begin
        step    = !abort && (rep_cnt == '0);
        step_up = rep_up;
      end
      default: ;
    endcase
  end

  // Auto-repeat FSM and button edge registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rep_cnt <= '0;
      rep_up  <= 1'b0;
      rep_sel <= 2'b00;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
    end else begin
      inc_q <= bus.inc_btn;
      dec_q <= bus.dec_btn;
      case (state)
        IDLE: begin
          if (arm) begin
            state   <= DELAY;
            rep_cnt <= RW'(REP_DELAY - 1);
            rep_up  <= inc_press;
            rep_sel <= bus.sel;
          end
        end
        DELAY, REPEAT: begin
          if (abort) begin
            state <= IDLE;
          end else if (rep_cnt == '0) begin
            state   <= REPEAT;
            rep_cnt <= RW'(REP_RATE - 1);
          end else begin
            rep_cnt <= rep_cnt - RW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Prescaler, timekeeping with carries, and edit steps on the selected field.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc  <= '0;
      s_r    <= '0;
      m_r    <= '0;
      h_r    <= '0;
      tick_r <= 1'b0;
      wrap_r <= 1'b0;
    end else if (presc_wrap) begin
      presc  <= '0;
      tick_r <= 1'b1;
      wrap_r <= (s_r == 6'd59) && (m_r == 6'd59) && (h_r == 5'd23);
      if (s_r == 6'd59) begin
        s_r <= '0;
        if (m_r == 6'd59) begin
          m_r <= '0;
          h_r <= (h_r == 5'd23) ? 5'd0 : h_r + 5'd1;
        end else begin
          m_r <= m_r + 6'd1;
        end
      end else begin
        s_r <= s_r + 6'd1;
      end
    end else begin
      presc  <= counting ? presc + PW'(1) : '0;
      tick_r <= 1'b0;
      wrap_r <= 1'b0;
      if (step) begin
        case (bus.sel)
          2'b01:   s_r <= step_field(s_r, 6'd59, step_up);
          2'b10:   m_r <= step_field(m_r, 6'd59, step_up);
          2'b11:   h_r <= 5'(step_field({1'b0, h_r}, 6'd23, step_up));
          default: ;
        endcase
      end
    end
  end

  assign bus.s           = s_r;
  assign bus.m           = m_r;
  assign bus.h           = h_r;
  assign bus.tick_1hz    = tick_r;
  assign bus.day_wrap    = wrap_r;
  assign bus.pm          = (h_r >= 5'd12);
  assign bus.h_disp      = (h_r == 5'd0)  ? 5'd12 :
                           (h_r > 5'd12)  ? h_r - 5'd12 : h_r;
  assign bus.edit_active = (bus.sel != 2'b00);

endmodule

// File: tb/tb_time_of_day_counter.sv
// Bench for time_of_day_counter: directed scenarios then random stimulus,
// checked every cycle against a seconds-of-day reference model.
module tb_time_of_day_counter;

  localparam int unsigned CLK_DIV   = 4;
  localparam int unsigned REP_DELAY = 6;
  localparam int unsigned REP_RATE  = 2;

  logic clk = 1'b0;
  logic reset;

  time_of_day_counter_if bus ();

  time_of_day_counter #(
    .CLK_DIV  (CLK_DIV),
    .REP_DELAY(REP_DELAY),
    .REP_RATE (REP_RATE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: time as seconds since midnight, cycles since counting
  // enabled, and age (cycles since press) of the currently held button.
  int         t;
  int         pc;
  int         age;
  bit         armed;
  bit         up;
  bit         pinc;
  bit         pdec;
  logic [1:0] hsel;
  bit         e_tick;
  bit         e_wrap;

  function automatic int edit_field(input int tt, input logic [1:0] f, input bit u);
    int hh = tt / 3600;
    int mm = (tt / 60) % 60;
    int ss = tt % 60;
    case (f)
      2'd1: ss = (ss + (u ? 1 : 59)) % 60;
      2'd2: mm = (mm + (u ? 1 : 59)) % 60;
      2'd3: hh = (hh + (u ? 1 : 23)) % 24;
      default: ;
    endcase
    return hh * 3600 + mm * 60 + ss;
  endfunction

  task automatic model_reset();
    t = 0; pc = 0; age = 0; armed = 0; up = 0;
    pinc = 0; pdec = 0; hsel = 2'b00; e_tick = 0; e_wrap = 0;
  endtask

  task automatic model_step();
    bit do_step = 0;
    bit inc = bus.inc_btn;
    bit dec = bus.dec_btn;
    e_tick = 0;
    e_wrap = 0;
    if (bus.run && bus.sel == 2'b00) begin
      pc++;
      if (pc == int'(CLK_DIV)) begin
        pc = 0;
        e_tick = 1;
        e_wrap = (t == 86399);
        t = (t + 1) % 86400;
      end
    end else begin
      pc = 0;
    end
    if (armed) begin
      if ((up ? !inc : !dec) || (up ? dec : inc) || bus.sel != hsel || bus.sel == 2'b00) begin
        armed = 0;
      end else begin
        age++;
        if (age >= int'(REP_DELAY) && (age - int'(REP_DELAY)) % int'(REP_RATE) == 0)
          do_step = 1;
      end
    end else if (bus.sel != 2'b00 && ((inc && !pinc) || (dec && !pdec)) && !(inc && dec)) begin
      armed   = 1;
      age     = 0;
      up      = inc && !pinc;
      hsel    = bus.sel;
      do_step = 1;
    end
    pinc = inc;
    pdec = dec;
    if (do_step) t = edit_field(t, bus.sel, up);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int hh = t / 3600;
    chk("s", 32'(bus.s), 32'(t % 60));
    chk("m", 32'(bus.m), 32'((t / 60) % 60));
    chk("h", 32'(bus.h), 32'(hh));
    chk("h_disp", 32'(bus.h_disp), 32'((hh % 12 == 0) ? 12 : hh % 12));
    chk("pm", 32'(bus.pm), 32'(hh >= 12));
    chk("tick_1hz", 32'(bus.tick_1hz), 32'(e_tick));
    chk("day_wrap", 32'(bus.day_wrap), 32'(e_wrap));
    chk("edit_active", 32'(bus.edit_active), 32'(bus.sel != 2'b00));
  endtask

  task automatic cycle(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (!reset) model_step();
      #1;
      check_all();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic press_inc();
    bus.inc_btn = 1'b1; cycle();
    bus.inc_btn = 1'b0; cycle();
  endtask

  task automatic press_dec();
    bus.dec_btn = 1'b1; cycle();
    bus.dec_btn = 1'b0; cycle();
  endtask

  int hv[6]  = '{0, 1, 11, 12, 13, 23};
  int hdv[6] = '{12, 1, 11, 12, 1, 11};
  int pmv[6] = '{0, 0, 0, 1, 1, 1};

  initial begin
    reset = 1'b1;
    bus.run = 1'b0; bus.sel = 2'b00; bus.inc_btn = 1'b0; bus.dec_btn = 1'b0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    reset = 1'b0;

    // First tick after CLK_DIV cycles, minute carry after 60 seconds.
    bus.run = 1'b1;
    cycle(3);
    chk("pre_tick", 32'(bus.tick_1hz), 32'd0);
    cycle(1);
    chk("first_tick", 32'(bus.tick_1hz), 32'd1);
    chk("first_s", 32'(bus.s), 32'd1);
    cycle(236);
    chk("min_m", 32'(bus.m), 32'd1);
    chk("min_s", 32'(bus.s), 32'd0);

    // Preload 23:59:58 by editing, then count through midnight.
    do_reset();
    bus.run = 1'b0;
    bus.sel = 2'b11; press_dec();
    bus.sel = 2'b10; press_dec();
    bus.sel = 2'b01; press_dec(); press_dec();
    chk("pre_h", 32'(bus.h), 32'd23);
    chk("pre_m", 32'(bus.m), 32'd59);
    chk("pre_s", 32'(bus.s), 32'd58);
    bus.sel = 2'b00; bus.run = 1'b1;
    cycle(4);
    chk("s59", 32'(bus.s), 32'd59);
    cycle(3);
    chk("no_wrap_yet", 32'(bus.day_wrap), 32'd0);
    cycle(1);
    chk("wrap_pulse", 32'(bus.day_wrap), 32'd1);
    chk("wrap_tick", 32'(bus.tick_1hz), 32'd1);
    chk("wrap_h", 32'(bus.h), 32'd0);
    cycle(1);
    chk("wrap_one_cycle", 32'(bus.day_wrap), 32'd0);

    // Minute decrement wraps with no borrow; prescaler held at 0 in edit.
    bus.sel = 2'b10;
    press_dec();
    chk("m_dec_wrap", 32'(bus.m), 32'd59);
    chk("h_kept", 32'(bus.h), 32'd0);
    cycle(3);
    bus.sel = 2'b00;
    cycle(3);
    chk("presc_held", 32'(bus.tick_1hz), 32'd0);
    cycle(1);
    chk("tick_after_edit", 32'(bus.tick_1hz), 32'd1);

    // Hold inc for 14 cycles: steps at 0, 6, 8, 10, 12.
    bus.run = 1'b0; bus.sel = 2'b11;
    bus.inc_btn = 1'b1;
    cycle(14);
    chk("hold_h5", 32'(bus.h), 32'd5);
    bus.inc_btn = 1'b0;
    cycle(10);
    chk("release_h5", 32'(bus.h), 32'd5);

    // Dec asserted mid-repeat stops stepping.
    bus.inc_btn = 1'b1;
    cycle(9);
    chk("repeat_h8", 32'(bus.h), 32'd8);
    bus.dec_btn = 1'b1;
    cycle(6);
    chk("both_held_h8", 32'(bus.h), 32'd8);
    bus.inc_btn = 1'b0; bus.dec_btn = 1'b0;
    cycle(2);

    // Sel change while held: nothing until re-press.
    bus.inc_btn = 1'b1;
    cycle(1);
    bus.sel = 2'b10;
    cycle(8);
    chk("selchg_h", 32'(bus.h), 32'd9);
    chk("selchg_m", 32'(bus.m), 32'd59);
    bus.inc_btn = 1'b0;
    cycle(1);
    press_inc();
    chk("repress_m", 32'(bus.m), 32'd0);

    // 12-hour conversion sweep.
    do_reset();
    bus.sel = 2'b11;
    for (int k = 0; k < 6; k++) begin
      for (int g = 0; g < 24 && bus.h != 5'(hv[k]); g++) press_inc();
      chk("sweep_h", 32'(bus.h), 32'(hv[k]));
      chk("sweep_h_disp", 32'(bus.h_disp), 32'(hdv[k]));
      chk("sweep_pm", 32'(bus.pm), 32'(pmv[k]));
    end

    // Reset during REPEAT clears at once; no step after release.
    do_reset();
    bus.sel = 2'b11;
    bus.inc_btn = 1'b1;
    cycle(10);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    chk("async_rst_h", 32'(bus.h), 32'd0);
    bus.inc_btn = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cycle(10);
    chk("post_rst_h", 32'(bus.h), 32'd0);

    // Random run/sel/button activity against the model.
    bus.sel = 2'b00; bus.run = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(15) == 0) bus.sel = 2'($urandom_range(3));
      if ($urandom_range(3) == 0) bus.inc_btn = ~bus.inc_btn;
      if ($urandom_range(5) == 0) bus.dec_btn = ~bus.dec_btn;
      bus.run = ($urandom_range(7) != 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/time_of_day_counter.md
Name: time_of_day_counter

Overview:
Parametrised 24-hour time-of-day counter for the board-level timer. It runs from the fast system clock with an internal 1 Hz prescaler instead of a divided clock. It adds an edit mode with increment and decrement, hold-to-auto-repeat, a 12-hour display conversion and a day-wrap pulse. It sits between the debounced button front-end and the seven-segment display mux.

Parameters:
CLK_DIV, 100000000, clk cycles per counted second; must be >= 2.
REP_DELAY, 50000000, clk cycles a button must be held after its press step before auto-repeat begins; must be >= 1.
REP_RATE, 10000000, clk cycles between auto-repeat steps; must be >= 1.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
run  input  1  1 = timekeeping enabled when not editing
sel  input  2  field select for edit: 00 none (normal run), 01 seconds, 10 minutes, 11 hours
inc_btn  input  1  increment button, debounced level, synchronous to clk
dec_btn  input  1  decrement button, debounced level, synchronous to clk
s  output  6  seconds, 0..59, registered
m  output  6  minutes, 0..59, registered
h  output  5  hours, 0..23, registered
h_disp  output  5  12-hour display value, 1..12, combinational from h
pm  output  1  1 when h >= 12, combinational
tick_1hz  output  1  one-cycle pulse on each counted second, registered
day_wrap  output  1  one-cycle pulse on a 23:59:59 -> 00:00:00 rollover caused by counting, registered
edit_active  output  1  equals (sel != 00), combinational

Behaviour:
- Interface: reset is asynchronous, active-high; clock is clk. All state updates on the rising edge of clk.
- Reset values: s = m = h = 0, prescaler = 0, tick_1hz = 0, day_wrap = 0, button edge registers = 0, auto-repeat FSM = IDLE.
- Prescaler:
  - Width is $clog2(CLK_DIV).
  - Advances only when run = 1 and sel = 00; otherwise it is held at 0.
  - When the count equals CLK_DIV-1, it returns to 0 and tick_1hz is asserted on the next cycle.
  - Result: the first tick arrives CLK_DIV cycles after counting is enabled.
- Counting, on tick:
  - s increments; 59 wraps to 0 and carries to m.
  - m increments only on a seconds carry; 59 wraps to 0 and carries to h.
  - h increments only on a minutes carry; 23 wraps to 0.
  - day_wrap pulses in the same cycle tick_1hz pulses for the 23:59:59 -> 00:00:00 transition.
- Edit mode (sel != 00):
  - Counting is frozen and the prescaler is held at 0.
  - The selected field steps by +1 (inc) or -1 (dec) within its own range, with no carry or borrow into other fields.
  - Wrap limits: s and m 59 <-> 0; h 23 <-> 0.
  - tick_1hz and day_wrap are never asserted by edits.
- Press detection:
  - btn_q registers each button; a press is btn & ~btn_q.
  - A press step is applied on the same clock edge at which the press is detected.
- Auto-repeat FSM, per module (not per button):
  - IDLE: on an inc or dec press with sel != 00, apply one step, load the repeat counter with REP_DELAY-1, go to DELAY.
  - DELAY: the counter decrements each cycle while the same button is still held. At 0, apply a step, load REP_RATE-1, go to REPEAT.
  - REPEAT: at counter 0, apply a step and reload REP_RATE-1.
  - From DELAY or REPEAT, return to IDLE (no step) if any of the following occur: the held button is released, the other button is asserted, sel changes value, or sel = 00.
- Simultaneous inc and dec: no step, FSM to IDLE; a fresh press edge is then required.
- A press while sel = 00 is ignored and does not arm the FSM.
- Changing sel while a button is held: no step until the button is released and pressed again.
- 12-hour conversion: h_disp = 12 if h = 0; h-12 if h > 12; otherwise h.
- Reset asserted mid-edit or mid-repeat: immediate return to reset values; no pending step is applied after reset deassertion.

Test Plan:
(Bench parameters: CLK_DIV=4, REP_DELAY=6, REP_RATE=2.)
- Reset, then run=1, sel=00 for 4 cycles -> first tick_1hz in cycle 4, s=1; after 240 cycles -> m=1, s=0.
- Preload 23:59:58 via edit, then run 2 ticks -> 23:59:59, then 00:00:00 with day_wrap = 1 for exactly one cycle coincident with tick_1hz.
- sel=10, m=0, dec_btn one-cycle press -> m=59; h unchanged; no day_wrap; the prescaler stays at 0 throughout.
- sel=11, hold inc_btn for 14 cycles from h=0 -> steps at cycles 0, 6, 8, 10, 12 -> h=5; release -> no further steps.
- Hold inc_btn, assert dec_btn mid-repeat -> no further steps. Change sel while inc is held -> no step until a re-press.
- h sweep 0, 1, 11, 12, 13, 23 -> h_disp/pm = 12/0, 1/0, 11/0, 12/1, 1/1, 11/1. Reset asserted during REPEAT -> all outputs 0 at once, and no step after reset is released.
